// File: rtl/img_axis_framer.sv
// Re-frames the 64-bit local pixel stream as AXI4-Stream video (tuser/tlast/tid).
// A FIFO feeding a registered FWFT output stage absorbs tready stalls.
module img_axis_framer #(
  parameter int DATA_W         = 64,
  parameter int WORDS_PER_LINE = 256,
  parameter int LINES          = 2048,
  parameter int FIFO_AW        = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_vld,
  input  logic              frame_start,
  input  logic [1:0]        frame_type,
  input  logic              unexpected_data,
  input  logic              unexpected_tlast,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  output logic [1:0]        m_axis_tid,
  output logic              frame_done,
  output logic              frame_err,
  output logic              frame_trunc,
  output logic              fifo_ovf,
  output logic [15:0]       stray_cnt,
  output logic [15:0]       frame_cnt,
  input  logic              stat_clr
);

  // state    | meaning
  // S_IDLE   | outside a frame, words counted as stray
  // S_ARMED  | frame_start seen, next word is word 0
  // S_ACTIVE | inside a frame, col/line tracking geometry

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam int LW    = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int EW    = DATA_W + 4;
  localparam logic [FIFO_AW:0] FULL_OCC = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_ACTIVE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [1:0]         type_q, type_d;
  logic               err_q, err_d;
  logic [CW-1:0]      col_q, col_d, cur_col;
  logic [LW-1:0]      line_q, line_d, cur_line;
  logic               done_q, done_d, ferr_q, ferr_d, trunc_q, trunc_d;
  logic               ovf_q;
  logic [15:0]        stray_q, fcnt_q;

  logic [EW-1:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   cnt_q, occ;
  logic               out_vld_q;
  logic [EW-1:0]      out_q;

  logic pop, load, wr_req, wr, ovf_now, ev, w_user, w_last;

  // Occupancy includes the output register so total capacity is DEPTH words.
  assign pop      = out_vld_q & m_axis_tready;
  assign load     = (cnt_q != '0) & (~out_vld_q | m_axis_tready);
  assign occ      = cnt_q + {{FIFO_AW{1'b0}}, out_vld_q};
  assign wr_req   = din_vld & (state_q != S_IDLE);
  assign wr       = wr_req & ((occ != FULL_OCC) | pop);
  assign ovf_now  = wr_req & ~wr;
  assign ev       = unexpected_data | unexpected_tlast | ovf_now;
  assign cur_col  = (state_q == S_ACTIVE) ? col_q : '0;
  assign cur_line = (state_q == S_ACTIVE) ? line_q : '0;
  assign w_user   = (state_q == S_ARMED);
  assign w_last   = (cur_col == CW'(WORDS_PER_LINE-1));

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    err_d   = err_q;
    col_d   = col_q;
    line_d  = line_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    trunc_d = 1'b0;
    if ((state_q != S_IDLE) && ev) err_d = 1'b1;
    // The word is accounted to the current state before frame_start is applied.
    if (wr_req) begin
      state_d = S_ACTIVE;
      col_d   = w_last ? '0 : cur_col + CW'(1);
      line_d  = w_last ? cur_line + LW'(1) : cur_line;
      if (w_last && (cur_line == LW'(LINES-1))) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        ferr_d  = err_q | ev;
        col_d   = '0;
        line_d  = '0;
      end
    end
    if (frame_start) begin
      if (state_d == S_ACTIVE) begin
        trunc_d = 1'b1;
        ferr_d  = 1'b1;
      end
      state_d = S_ARMED;
      type_d  = frame_type;
      err_d   = 1'b0;
      col_d   = '0;
      line_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      type_q    <= '0;
      err_q     <= 1'b0;
      col_q     <= '0;
      line_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      trunc_q   <= 1'b0;
      ovf_q     <= 1'b0;
      stray_q   <= '0;
      fcnt_q    <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      err_q   <= err_d;
      col_q   <= col_d;
      line_q  <= line_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      trunc_q <= trunc_d;
      if (wr)   wptr_q <= wptr_q + 1'b1;
      if (load) rptr_q <= rptr_q + 1'b1;
      if (wr && !load)      cnt_q <= cnt_q + 1'b1;
      else if (!wr && load) cnt_q <= cnt_q - 1'b1;
      if (load) begin
        out_q     <= mem[rptr_q];
        out_vld_q <= 1'b1;
      end else if (pop) begin
        out_vld_q <= 1'b0;
      end
      if (stat_clr) begin
        stray_q <= '0;
        fcnt_q  <= '0;
        ovf_q   <= 1'b0;
      end else begin
        if (din_vld && (state_q == S_IDLE) && (stray_q != 16'hFFFF)) stray_q <= stray_q + 16'd1;
        if (done_d)  fcnt_q <= fcnt_q + 16'd1;
        if (ovf_now) ovf_q  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr_q] <= {type_q, w_user, w_last, din};
  end

  assign m_axis_tdata  = out_q[DATA_W-1:0];
  assign m_axis_tlast  = out_q[DATA_W];
  assign m_axis_tuser  = out_q[DATA_W+1];
  assign m_axis_tid    = out_q[DATA_W+3:DATA_W+2];
  assign m_axis_tvalid = out_vld_q;
  assign frame_done    = done_q;
  assign frame_err     = ferr_q;
  assign frame_trunc   = trunc_q;
  assign fifo_ovf      = ovf_q;
  assign stray_cnt     = stray_q;
  assign frame_cnt     = fcnt_q;

endmodule

// File: tb/tb_img_axis_framer.sv
// Bench for img_axis_framer: directed scenario table, hand sequences and random traffic,
// all compared cycle by cycle against a queue-based frame/FIFO reference model.
module tb_img_axis_framer;

  localparam int DW    = 64;
  localparam int WPL   = 4;
  localparam int LN    = 3;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;
  localparam int TOTAL = WPL * LN;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] din;
  logic          din_vld, frame_start, unexpected_data, unexpected_tlast, m_axis_tready, stat_clr;
  logic [1:0]    frame_type;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tuser, m_axis_tlast;
  logic [1:0]    m_axis_tid;
  logic          frame_done, frame_err, frame_trunc, fifo_ovf;
  logic [15:0]   stray_cnt, frame_cnt;

  always #5 clk = ~clk;

  img_axis_framer #(.DATA_W(DW), .WORDS_PER_LINE(WPL), .LINES(LN), .FIFO_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .frame_start(frame_start),
    .frame_type(frame_type), .unexpected_data(unexpected_data), .unexpected_tlast(unexpected_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
    .frame_done(frame_done), .frame_err(frame_err), .frame_trunc(frame_trunc),
    .fifo_ovf(fifo_ovf), .stray_cnt(stray_cnt), .frame_cnt(frame_cnt), .stat_clr(stat_clr));

  // Reference model: frame position as a word index, words in flight as a queue.
  typedef struct {logic [DW-1:0] d; logic u; logic l; logic [1:0] id;} ent_t;
  ent_t       mq[$];
  int         m_state, m_idx, m_stray, m_fcnt, mem_before, idx;
  logic [1:0] m_type;
  bit         m_err, m_vis, m_done, m_ferr, m_trunc, m_ovf, started;
  bit         m_pop, m_load, wr_req, room, ovf_now;
  ent_t       e;

  always @(posedge clk) begin
    started = 1'b1;
    m_done  = 1'b0;
    m_ferr  = 1'b0;
    m_trunc = 1'b0;
    if (!rst_n) begin
      mq.delete();
      m_vis = 1'b0; m_state = 0; m_idx = 0; m_type = 2'd0; m_err = 1'b0;
      m_ovf = 1'b0; m_stray = 0; m_fcnt = 0;
    end else begin
      mem_before = mq.size() - (m_vis ? 1 : 0);
      m_pop   = m_vis && m_axis_tready;
      m_load  = (mem_before > 0) && (!m_vis || m_axis_tready);
      wr_req  = din_vld && (m_state != 0);
      room    = (mq.size() < DEPTH) || m_pop;
      ovf_now = wr_req && !room;
      if (m_state != 0 && (unexpected_data || unexpected_tlast || ovf_now)) m_err = 1'b1;
      if (din_vld) begin
        if (m_state == 0) begin
          if (m_stray < 65535) m_stray++;
        end else begin
          idx  = (m_state == 1) ? 0 : m_idx;
          e.d  = din;
          e.u  = (idx == 0);
          e.l  = ((idx % WPL) == WPL - 1);
          e.id = m_type;
          if (room) mq.push_back(e);
          if (idx == TOTAL - 1) begin
            m_done = 1'b1; m_ferr = m_err; m_state = 0; m_fcnt = (m_fcnt + 1) % 65536;
          end else begin
            m_state = 2; m_idx = idx + 1;
          end
        end
      end
      if (ovf_now) m_ovf = 1'b1;
      if (frame_start) begin
        if (m_state == 2) begin m_trunc = 1'b1; m_ferr = 1'b1; end
        m_state = 1; m_type = frame_type; m_err = 1'b0;
      end
      if (stat_clr) begin m_stray = 0; m_fcnt = 0; m_ovf = 1'b0; end
      if (m_pop) void'(mq.pop_front());
      m_vis = (m_vis && !m_axis_tready) || m_load;
    end
  end

  int checks = 0;
  int errors = 0;
  int beats = 0, users = 0, dones = 0, errs = 0, truncs = 0;
  bit beat_last[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Beats are counted before the edge that consumes them; outputs checked at the negedge.
  task automatic tick();
    if (m_axis_tvalid && m_axis_tready) begin
      beats++;
      if (m_axis_tuser) users++;
      beat_last.push_back(m_axis_tlast);
    end
    @(posedge clk);
    #1;
    din_vld = 1'b0; frame_start = 1'b0; unexpected_data = 1'b0;
    unexpected_tlast = 1'b0; stat_clr = 1'b0;
    @(negedge clk);
    if (started) begin
      chk("tvalid", 64'(m_axis_tvalid), 64'(m_vis));
      if (m_vis && mq.size() > 0) begin
        chk("tdata", m_axis_tdata, mq[0].d);
        chk("tuser", 64'(m_axis_tuser), 64'(mq[0].u));
        chk("tlast", 64'(m_axis_tlast), 64'(mq[0].l));
        chk("tid",   64'(m_axis_tid),   64'(mq[0].id));
      end
      chk("frame_done",  64'(frame_done),  64'(m_done));
      chk("frame_err",   64'(frame_err),   64'(m_ferr));
      chk("frame_trunc", 64'(frame_trunc), 64'(m_trunc));
      chk("fifo_ovf",    64'(fifo_ovf),    64'(m_ovf));
      chk("stray_cnt",   64'(stray_cnt),   64'(m_stray));
      chk("frame_cnt",   64'(frame_cnt),   64'(m_fcnt));
    end
    if (frame_done)  dones++;
    if (frame_err)   errs++;
    if (frame_trunc) truncs++;
  endtask

  task automatic word(input bit ud, input bit ut);
    din = {$urandom, $urandom};
    din_vld = 1'b1;
    unexpected_data = ud;
    unexpected_tlast = ut;
    tick();
  endtask

  task automatic drain();
    m_axis_tready = 1'b1;
    repeat (2) tick();
    for (int k = 0; k < 40 && m_axis_tvalid; k++) tick();
    chk("drain_timeout", 64'(m_axis_tvalid), 64'd0);
    tick();
  endtask

  typedef struct {
    bit fs; logic [1:0] ft; int nw; bit stall; bit gap;
    int exp_beats; int exp_users; int exp_done; int exp_err;
    logic [11:0] exp_lastmask; bit exp_ovf; int exp_stray; int exp_fcnt;
  } vec_t;
  vec_t tbl[4];

  int b0, u0, d0, e0, t0, l0;
  logic [11:0] mask;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b1, 2'd2, 12, 1'b0, 1'b0, 12, 1, 1, 0, 12'h888, 1'b0, 0, 1};
    tbl[1] = '{1'b0, 2'd0,  5, 1'b0, 1'b0,  0, 0, 0, 0, 12'h000, 1'b0, 5, 0};
    tbl[2] = '{1'b1, 2'd1, 12, 1'b1, 1'b0,  8, 1, 1, 1, 12'h088, 1'b1, 0, 1};
    tbl[3] = '{1'b1, 2'd3, 12, 1'b0, 1'b1, 12, 1, 1, 0, 12'h888, 1'b0, 0, 1};

    rst_n = 1'b0; din = '0; din_vld = 1'b0; frame_start = 1'b0; frame_type = 2'd0;
    unexpected_data = 1'b0; unexpected_tlast = 1'b0; m_axis_tready = 1'b1; stat_clr = 1'b0;
    repeat (3) tick();
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_stray",  64'(stray_cnt), 64'd0);
    chk("rst_fcnt",   64'(frame_cnt), 64'd0);
    chk("rst_ovf",    64'(fifo_ovf), 64'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      stat_clr = 1'b1;
      tick();
      b0 = beats; u0 = users; d0 = dones; e0 = errs; l0 = beat_last.size();
      m_axis_tready = !tbl[i].stall;
      if (tbl[i].fs) begin
        frame_start = 1'b1; frame_type = tbl[i].ft;
        tick();
      end
      for (int w = 0; w < tbl[i].nw; w++) begin
        word(1'b0, 1'b0);
        if (tbl[i].gap) tick();
      end
      if (tbl[i].stall) repeat (4) tick();
      drain();
      chk($sformatf("tbl%0d_beats", i), 64'(beats - b0), 64'(tbl[i].exp_beats));
      chk($sformatf("tbl%0d_users", i), 64'(users - u0), 64'(tbl[i].exp_users));
      chk($sformatf("tbl%0d_done", i),  64'(dones - d0), 64'(tbl[i].exp_done));
      chk($sformatf("tbl%0d_err", i),   64'(errs - e0),  64'(tbl[i].exp_err));
      mask = '0;
      for (int k = 0; k < 12; k++)
        if (l0 + k < beat_last.size()) mask[k] = beat_last[l0 + k];
      chk($sformatf("tbl%0d_lastmask", i), 64'(mask), 64'(tbl[i].exp_lastmask));
      chk($sformatf("tbl%0d_ovf", i),   64'(fifo_ovf),  64'(tbl[i].exp_ovf));
      chk($sformatf("tbl%0d_stray", i), 64'(stray_cnt), 64'(tbl[i].exp_stray));
      chk($sformatf("tbl%0d_fcnt", i),  64'(frame_cnt), 64'(tbl[i].exp_fcnt));
    end

    // Truncation: 6 words, new frame_start, then a full type-1 frame.
    stat_clr = 1'b1; tick();
    b0 = beats; u0 = users; d0 = dones; e0 = errs; t0 = truncs;
    frame_start = 1'b1; frame_type = 2'd0; tick();
    repeat (6) word(1'b0, 1'b0);
    frame_start = 1'b1; frame_type = 2'd1; tick();
    chk("trunc_pulse", 64'(frame_trunc), 64'd1);
    chk("trunc_err",   64'(frame_err), 64'd1);
    repeat (12) word(1'b0, 1'b0);
    drain();
    chk("trunc_beats",  64'(beats - b0), 64'd18);
    chk("trunc_users",  64'(users - u0), 64'd2);
    chk("trunc_count",  64'(truncs - t0), 64'd1);
    chk("trunc_done",   64'(dones - d0), 64'd1);
    chk("trunc_errs",   64'(errs - e0), 64'd1);
    chk("trunc_fcnt",   64'(frame_cnt), 64'd1);

    // unexpected_tlast mid-frame flags the frame at frame_done.
    b0 = beats; d0 = dones; e0 = errs;
    frame_start = 1'b1; frame_type = 2'd2; tick();
    for (int w = 0; w < 12; w++) word(1'b0, w == 5);
    drain();
    chk("ut_beats", 64'(beats - b0), 64'd12);
    chk("ut_done",  64'(dones - d0), 64'd1);
    chk("ut_err",   64'(errs - e0), 64'd1);

    // Reset mid-frame with FIFO non-empty.
    m_axis_tready = 1'b0;
    frame_start = 1'b1; frame_type = 2'd3; tick();
    repeat (6) word(1'b0, 1'b0);
    chk("pre_rst_tvalid", 64'(m_axis_tvalid), 64'd1);
    rst_n = 1'b0; tick();
    chk("rst_mid_tvalid", 64'(m_axis_tvalid), 64'd0);
    rst_n = 1'b1; m_axis_tready = 1'b1;
    b0 = beats;
    repeat (3) word(1'b0, 1'b0);
    repeat (4) tick();
    chk("rst_mid_stray", 64'(stray_cnt), 64'd3);
    chk("rst_mid_beats", 64'(beats - b0), 64'd0);

    // stat_clr wins over a same-cycle stray increment.
    din_vld = 1'b1; din = 64'h1; stat_clr = 1'b1; tick();
    chk("clr_wins", 64'(stray_cnt), 64'd0);
    word(1'b0, 1'b0);
    chk("stray_after_clr", 64'(stray_cnt), 64'd1);

    // frame_start with din_vld in IDLE: word is stray, then a full frame follows.
    b0 = beats; u0 = users;
    din_vld = 1'b1; din = 64'h5; frame_start = 1'b1; frame_type = 2'd1; tick();
    chk("fs_dv_stray", 64'(stray_cnt), 64'd2);
    repeat (12) word(1'b0, 1'b0);
    drain();
    chk("fs_dv_beats", 64'(beats - b0), 64'd12);
    chk("fs_dv_users", 64'(users - u0), 64'd1);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      frame_start      = ($urandom_range(99) < 3);
      frame_type       = 2'($urandom_range(3));
      din_vld          = ($urandom_range(99) < 65);
      din              = {$urandom, $urandom};
      unexpected_data  = ($urandom_range(99) < 2);
      unexpected_tlast = ($urandom_range(99) < 2);
      stat_clr         = ($urandom_range(99) < 2);
      m_axis_tready    = ($urandom_range(99) < 70);
      tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
